sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_pkg.sv | 19 +
 rtl/sprite_blitter_fb_addr_calc.sv | 27 ++
 rtl/sprite_blitter.sv | 147 ++++++++++++++
 tb/tb_sprite_blitter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the sprite blitter.
package sprite_pkg;

  localparam int unsigned SPR_W_DEF = 32;
  localparam int unsigned SPR_H_DEF = 32;
  localparam int unsigned FB_W_DEF  = 320;
  localparam int unsigned FB_H_DEF  = 240;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned FB_ADDR_W = 17;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/sprite_blitter_fb_addr_calc.sv
// Maps sprite row/col plus latched origin to a frame-buffer address and a clip flag.
module fb_addr_calc
  import sprite_pkg::*;
#(
  parameter int unsigned FB_W = FB_W_DEF,
  parameter int unsigned FB_H = FB_H_DEF
) (
  input  logic [COORD_W-1:0]   org_x,
  input  logic [COORD_W-1:0]   org_y,
  input  logic [COORD_W-1:0]   row,
  input  logic [COORD_W-1:0]   col,
  output logic [FB_ADDR_W-1:0] addr_c,
  output logic                 clip_c
);

  logic [COORD_W:0] x;
  logic [COORD_W:0] y;

  // One extra bit so positions past the frame edge never wrap back on screen.
  always_comb begin
    x      = (COORD_W+1)'(org_x) + (COORD_W+1)'(col);
    y      = (COORD_W+1)'(org_y) + (COORD_W+1)'(row);
    clip_c = (32'(x) >= FB_W) || (32'(y) >= FB_H);
    addr_c = FB_ADDR_W'(32'(y) * FB_W + 32'(x));
  end

endmodule

// File: rtl/sprite_blitter.sv
// Copies a palette-indexed sprite from ROM into the frame buffer, skipping
// transparent and off-screen pixels.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W  = SPR_W_DEF,
  parameter int unsigned SPR_H  = SPR_H_DEF,
  parameter int unsigned FB_W   = FB_W_DEF,
  parameter int unsigned FB_H   = FB_H_DEF,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned TRANSP = 0
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [COORD_W-1:0]   pos_x,
  input  logic [COORD_W-1:0]   pos_y,
  output logic                 busy,
  output logic                 done,
  output logic [9:0]           rom_address,
  input  logic [IDX_W-1:0]     rom_q,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [IDX_W-1:0]     fb_data,
  input  logic                 fb_ready
);

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   org_x_q, org_x_d, org_y_q, org_y_d;
  logic [COORD_W-1:0]   row_q, row_d, col_q, col_d;
  logic [9:0]           rom_address_q, rom_address_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [IDX_W-1:0]     fb_data_q, fb_data_d;
  logic                 busy_q, busy_d, done_q, done_d, fb_we_q, fb_we_d;
  logic                 advance, last_pixel;
  logic [FB_ADDR_W-1:0] calc_addr_c;
  logic                 calc_clip_c;

  fb_addr_calc #(
    .FB_W(FB_W),
    .FB_H(FB_H)
  ) u_addr (
    .org_x (org_x_q),
    .org_y (org_y_q),
    .row   (row_q),
    .col   (col_q),
    .addr_c(calc_addr_c),
    .clip_c(calc_clip_c)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      org_x_q       <= '0;
      org_y_q       <= '0;
      row_q         <= '0;
      col_q         <= '0;
      rom_address_q <= '0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fb_we_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      org_x_q       <= org_x_d;
      org_y_q       <= org_y_d;
      row_q         <= row_d;
      col_q         <= col_d;
      rom_address_q <= rom_address_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fb_we_q       <= fb_we_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    org_x_d       = org_x_q;
    org_y_d       = org_y_q;
    row_d         = row_q;
    col_d         = col_q;
    rom_address_d = rom_address_q;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    advance       = 1'b0;
    last_pixel    = (row_q == COORD_W'(SPR_H - 1)) && (col_q == COORD_W'(SPR_W - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          org_x_d = pos_x;
          org_y_d = pos_y;
          row_d   = '0;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        if ((rom_q == IDX_W'(TRANSP)) || calc_clip_c) begin
          advance = 1'b1;
        end else begin
          fb_addr_d = calc_addr_c;
          fb_data_d = rom_q;
          state_d   = WRITE;
        end
      end
      WRITE: advance = fb_ready;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Raster-order step to the next sprite pixel, or finish after the last one.
    if (advance) begin
      if (last_pixel) begin
        state_d = DONE;
      end else begin
        state_d = FETCH;
        if (col_q == COORD_W'(SPR_W - 1)) begin
          col_d = '0;
          row_d = row_q + COORD_W'(1);
        end else begin
          col_d = col_q + COORD_W'(1);
        end
      end
    end

    // Outputs are registered, so they are derived from the state being entered.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    fb_we_d = (state_d == WRITE);
    if (state_d == FETCH) begin
      rom_address_d = 10'(32'(row_d) * SPR_W + 32'(col_d));
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fb_we       = fb_we_q;
  assign rom_address = rom_address_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized self-checking bench for sprite_blitter against a pixel-list reference model.
module tb_sprite_blitter;

  localparam int SW = 32;
  localparam int SH = 32;
  localparam int FW = 320;
  localparam int FH = 240;
  localparam int TR = 0;
  localparam int BOUND = 8000;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  pos_x = '0;
  logic [9:0]  pos_y = '0;
  logic        busy, done, fb_we;
  logic [9:0]  rom_address;
  logic [2:0]  rom_q;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_ready = 1'b1;

  logic [2:0] sprite [SW*SH];

  int errors = 0;
  int checks = 0;
  int exp_addr[$], exp_data[$], got_addr[$], got_data[$];
  int done_at, done_cnt, busy_gaps, hold_bad, first_hold, stalls, post_busy, post_done;
  bit timed_out;

  sprite_blitter #(
    .SPR_W(32), .SPR_H(32), .FB_W(320), .FB_H(240), .IDX_W(3), .TRANSP(0)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .start      (start),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .busy       (busy),
    .done       (done),
    .rom_address(rom_address),
    .rom_q      (rom_q),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_ready   (fb_ready)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous sprite ROM: data one cycle after the address.
  always @(posedge vga_clk) rom_q <= sprite[rom_address];

  task automatic fill(input int mode);
    for (int i = 0; i < SW*SH; i++) begin
      if (mode == 0)      sprite[i] = 3'd5;
      else if (mode == 1) sprite[i] = 3'(TR);
      else                sprite[i] = 3'($urandom_range(0, 7));
    end
  endtask

  // Reference: every opaque on-screen pixel in raster order.
  task automatic build_expected(input int x, input int y);
    exp_addr.delete();
    exp_data.delete();
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        int ax, ay;
        ax = x + c;
        ay = y + r;
        if (int'(sprite[r*SW + c]) != TR && ax < FW && ay < FH) begin
          exp_addr.push_back(ay * FW + ax);
          exp_data.push_back(int'(sprite[r*SW + c]));
        end
      end
    end
  endtask

  function automatic int expected_cycles(input int n_stall);
    return 2 * SW * SH + exp_addr.size() + n_stall;
  endfunction

  function automatic int diff_count();
    int n, m;
    m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    n = (got_addr.size() > exp_addr.size()) ? got_addr.size() - exp_addr.size()
                                            : exp_addr.size() - got_addr.size();
    for (int i = 0; i < m; i++)
      if (got_addr[i] != exp_addr[i] || got_data[i] != exp_data[i]) n++;
    return n;
  endfunction

  // Drives one blit and records writes, timing and handshake behaviour.
  // ready_mode: 0 always ready, 1 stall first write 4 cycles, 2 random.
  task automatic run_blit(input int x, input int y, input int ready_mode, input bit perturb);
    bit prev_we, prev_acc, rdy;
    logic [16:0] pa;
    logic [2:0] pd;
    got_addr.delete();
    got_data.delete();
    done_at = -1; done_cnt = 0; busy_gaps = 0; hold_bad = 0; first_hold = 0;
    stalls = 0; post_busy = 0; post_done = 0; timed_out = 0;
    prev_we = 0; prev_acc = 0; pa = '0; pd = '0;
    @(negedge vga_clk);
    pos_x = 10'(x);
    pos_y = 10'(y);
    start = 1'b1;
    fb_ready = 1'b1;
    for (int t = 0; t < BOUND; t++) begin
      @(negedge vga_clk);
      start = 1'b0;
      if (perturb) begin
        pos_x = 10'($urandom);
        pos_y = 10'($urandom);
        start = ($urandom_range(0, 3) == 0);
      end
      if (!busy) busy_gaps++;
      if (done) begin
        done_cnt++;
        done_at = t;
        if (perturb) start = 1'b1;
        break;
      end
      case (ready_mode)
        1:       rdy = !(fb_we && got_addr.size() == 0 && stalls < 4);
        2:       rdy = ($urandom_range(0, 2) != 0);
        default: rdy = 1'b1;
      endcase
      if (fb_we && !rdy) stalls++;
      if (fb_we && prev_we && !prev_acc && (fb_addr !== pa || fb_data !== pd)) hold_bad++;
      if (fb_we && got_addr.size() == 0) first_hold++;
      if (fb_we && rdy) begin
        got_addr.push_back(int'(fb_addr));
        got_data.push_back(int'(fb_data));
      end
      prev_we = fb_we;
      prev_acc = fb_we && rdy;
      pa = fb_addr;
      pd = fb_data;
      fb_ready = rdy;
    end
    if (done_at < 0) timed_out = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge vga_clk);
      start = 1'b0;
      fb_ready = 1'b1;
      if (busy) post_busy++;
      if (done) post_done++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    checks++;
    if ({busy, done, fb_we} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/fb_we=%b required 000", {busy, done, fb_we});
    end
    checks++;
    if (rom_address !== 10'd0 || fb_addr !== 17'd0 || fb_data !== 3'd0) begin
      errors++;
      $display("FAIL reset_bus: rom_address=%0d fb_addr=%0d fb_data=%0d required 0 0 0",
               rom_address, fb_addr, fb_data);
    end
    reset = 1'b0;
    repeat (3) @(negedge vga_clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b required 0", busy);
    end
  endtask

  task automatic test_opaque();
    fill(0);
    build_expected(0, 0);
    run_blit(0, 0, 0, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL opaque_timeout: no done within %0d cycles", BOUND); end
    checks++;
    if (got_addr.size() != 1024) begin
      errors++; $display("FAIL opaque_count: got %0d writes required 1024", got_addr.size());
    end
    checks++;
    if (diff_count() != 0) begin
      errors++; $display("FAIL opaque_writes: %0d differences required 0", diff_count());
    end
    checks++;
    if (got_addr.size() == 0 || got_addr[0] != 0 || got_addr[got_addr.size()-1] != 31*320+31) begin
      errors++;
      $display("FAIL opaque_ends: first/last fb_addr %0d/%0d required 0/9951",
               got_addr.size() ? got_addr[0] : -1,
               got_addr.size() ? got_addr[got_addr.size()-1] : -1);
    end
    checks++;
    if (done_at != expected_cycles(0) || done_at != 3072) begin
      errors++; $display("FAIL opaque_latency: done at %0d required 3072", done_at);
    end
    checks++;
    if (busy_gaps != 0 || post_busy != 0 || post_done != 0) begin
      errors++;
      $display("FAIL opaque_busy: gaps=%0d post_busy=%0d post_done=%0d required 0 0 0",
               busy_gaps, post_busy, post_done);
    end
  endtask

  task automatic test_transparent();
    fill(1);
    build_expected(10, 10);
    run_blit(10, 10, 0, 0);
    checks++;
    if (got_addr.size() != 0) begin
      errors++; $display("FAIL transp_writes: got %0d writes required 0", got_addr.size());
    end
    checks++;
    if (done_at != 2048) begin
      errors++; $display("FAIL transp_latency: done at %0d required 2048", done_at);
    end
  endtask

  task automatic test_clip();
    int max_a;
    fill(0);
    build_expected(300, 220);
    run_blit(300, 220, 0, 0);
    max_a = 0;
    foreach (got_addr[i]) if (got_addr[i] > max_a) max_a = got_addr[i];
    checks++;
    if (got_addr.size() != 400) begin
      errors++; $display("FAIL clip_count: got %0d writes required 400", got_addr.size());
    end
    checks++;
    if (max_a >= 76800) begin
      errors++; $display("FAIL clip_range: max fb_addr %0d required < 76800", max_a);
    end
    checks++;
    if (diff_count() != 0 || done_at != expected_cycles(0)) begin
      errors++;
      $display("FAIL clip_writes: diffs=%0d done at %0d required 0 and %0d",
               diff_count(), done_at, expected_cycles(0));
    end
  endtask

  task automatic test_stall();
    fill(0);
    build_expected(0, 0);
    run_blit(0, 0, 1, 0);
    checks++;
    if (first_hold != 5 || hold_bad != 0) begin
      errors++;
      $display("FAIL stall_hold: first write held %0d cycles, %0d unstable required 5 and 0",
               first_hold, hold_bad);
    end
    checks++;
    if (got_addr.size() != 1024 || diff_count() != 0) begin
      errors++;
      $display("FAIL stall_writes: got %0d writes, %0d diffs required 1024 and 0",
               got_addr.size(), diff_count());
    end
    checks++;
    if (done_at != expected_cycles(4)) begin
      errors++; $display("FAIL stall_latency: done at %0d required %0d", done_at, expected_cycles(4));
    end
  endtask

  task automatic test_reset_mid();
    bit reached;
    int seen_done;
    fill(2);
    @(negedge vga_clk);
    pos_x = 10'd40;
    pos_y = 10'd50;
    start = 1'b1;
    fb_ready = 1'b1;
    reached = 0;
    for (int t = 0; t < BOUND; t++) begin
      @(negedge vga_clk);
      start = 1'b0;
      if (busy && rom_address >= 10'(5*SW)) begin reached = 1; break; end
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL midreset_reach: row 5 not reached"); end
    reset = 1'b1;
    @(negedge vga_clk);
    checks++;
    if ({busy, fb_we, done} !== 3'b000 || rom_address !== 10'd0) begin
      errors++;
      $display("FAIL midreset_state: busy/fb_we/done=%b rom_address=%0d required 000 and 0",
               {busy, fb_we, done}, rom_address);
    end
    reset = 1'b0;
    seen_done = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge vga_clk);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++; $display("FAIL midreset_resume: %0d busy/done cycles required 0", seen_done);
    end
    build_expected(40, 50);
    run_blit(40, 50, 0, 0);
    checks++;
    if (diff_count() != 0 || done_at != expected_cycles(0)) begin
      errors++;
      $display("FAIL midreset_reblit: diffs=%0d done at %0d required 0 and %0d",
               diff_count(), done_at, expected_cycles(0));
    end
  endtask

  task automatic test_ignore_start();
    fill(2);
    build_expected(100, 60);
    run_blit(100, 60, 0, 1);
    checks++;
    if (diff_count() != 0) begin
      errors++; $display("FAIL ignore_origin: %0d differences required 0", diff_count());
    end
    checks++;
    if (done_cnt != 1 || post_done != 0 || post_busy != 0 || done_at != expected_cycles(0)) begin
      errors++;
      $display("FAIL ignore_done: done_cnt=%0d post_done=%0d post_busy=%0d at %0d required 1 0 0 %0d",
               done_cnt, post_done, post_busy, done_at, expected_cycles(0));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      int x, y;
      x = $urandom_range(0, 330);
      y = $urandom_range(0, 250);
      fill(2);
      build_expected(x, y);
      run_blit(x, y, 2, 0);
      checks++;
      if (diff_count() != 0 || hold_bad != 0) begin
        errors++;
        $display("FAIL random_writes(%0d,%0d): diffs=%0d unstable=%0d required 0 0",
                 x, y, diff_count(), hold_bad);
      end
      checks++;
      if (done_at != expected_cycles(stalls)) begin
        errors++;
        $display("FAIL random_latency(%0d,%0d): done at %0d required %0d",
                 x, y, done_at, expected_cycles(stalls));
      end
    end
  endtask

  initial begin
    test_reset();
    test_opaque();
    test_transparent();
    test_clip();
    test_stall();
    test_reset_mid();
    test_ignore_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
